// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave exposing N_REGS user-logic words as read-only registers, with a
// CTRL word that can freeze all channels into a shadow bank for coherent reads.
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_REGS       = 4,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [32*N_REGS-1:0]      user_data_in,
  output logic                      snap_done
);

  logic [31:0]                 w_addr, w_off, w_wdata, w_rdata, w_ctrl;
  logic [29:0]                 w_word;
  logic                        w_hit, w_ack_set, w_commit, w_trig;
  logic [N_REGS-1:0][31:0]     w_live;
  logic [N_REGS-1:0][31:0]     r_shadow;
  logic [31:0]                 r_dbus;
  logic [7:0]                  r_cnt;
  logic                        r_ack, r_wctrl, r_mode, r_snap_done;
  logic                        w_unused;

  // Bus bit 0 is the MSB, so a plain vector copy lands DBus[0] on bit 31.
  assign w_addr  = OPB_ABus;
  assign w_wdata = OPB_DBus;
  assign w_live  = user_data_in;

  assign w_off     = w_addr - C_BASEADDR;
  assign w_word    = w_off[31:2];
  assign w_hit     = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_ack_set = w_hit && !r_ack;

  // CTRL writes land on the ack cycle, using the data/BE the master holds then.
  assign w_commit  = r_ack && r_wctrl && OPB_BE[3];
  assign w_trig    = w_commit && w_wdata[1];

  assign w_ctrl = {8'd0, 8'(N_REGS), r_cnt, 7'd0, r_mode};

  always_comb begin
    w_rdata = '0;
    if (w_word == '0) begin
      w_rdata = w_ctrl;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (w_word == 30'(i + 1)) w_rdata = r_mode ? r_shadow[i] : w_live[i];
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      r_ack       <= 1'b0;
      r_dbus      <= '0;
      r_wctrl     <= 1'b0;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_snap_done <= 1'b0;
      r_shadow    <= '0;
    end else begin
      r_ack       <= w_ack_set;
      r_dbus      <= (w_ack_set && OPB_RNW) ? w_rdata : '0;
      r_wctrl     <= w_ack_set && !OPB_RNW && (w_word == '0);
      r_snap_done <= w_trig;
      if (w_commit) r_mode <= w_wdata[0];
      if (w_trig) begin
        r_shadow <= w_live;
        r_cnt    <= r_cnt + 8'd1;
      end
    end
  end

  assign Sl_DBus    = r_dbus;
  assign Sl_xferAck = r_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign snap_done  = r_snap_done;

  assign w_unused = ^{OPB_seqAddr, OPB_BE[0:2], w_wdata[31:2], w_off[1:0], C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed bench for opb_register_bank_simulink2ppc (N_REGS = 4, base 0).
module tb_opb_register_bank_simulink2ppc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:31]  abus, dbus, sl_dbus;
  logic [0:3]   be_s;
  logic         rnw_s, sel, seqaddr;
  logic         ack, erra, retry, tout, snap;
  logic [127:0] udi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_register_bank_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be_s),
    .OPB_DBus(dbus), .OPB_RNW(rnw_s), .OPB_select(sel), .OPB_seqAddr(seqaddr),
    .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(erra), .Sl_retry(retry),
    .Sl_toutSup(tout), .user_data_in(udi), .snap_done(snap)
  );

  // Bus driver: one transfer, ack searched for over a bounded window.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic acked, output int lat);
    acked = 1'b0; rd = '0; lat = 0;
    @(negedge clk);
    abus = addr; rnw_s = rnw; be_s = be; dbus = wd; sel = 1'b1;
    for (int i = 1; i <= 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; rd = sl_dbus; lat = i; end
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic a; int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, snap, erra, retry, tout} !== 5'b0 || sl_dbus !== 32'h0) begin
      errors++; $display("FAIL reset_outputs ack=%b snap=%b dbus=%h want all 0", ack, snap, sl_dbus);
    end
    @(negedge clk); rst_n = 1'b1;
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (a !== 1'b1 || lat != 1) begin
      errors++; $display("FAIL reset_ctrl_latency acked=%b lat=%0d want 1/1", a, lat);
    end
    checks++;
    if (rd !== 32'h0004_0000) begin
      errors++; $display("FAIL reset_ctrl_value got %h want 00040000", rd);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0 || sl_dbus !== 32'h0) begin
      errors++; $display("FAIL idle_bus ack=%b dbus=%h want 0/0", ack, sl_dbus);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_ack;
    @(negedge clk);
    abus = 32'h0; rnw_s = 1'b1; be_s = 4'b1111; sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      exp_ack = (k % 2 == 0);
      checks++;
      if (ack !== exp_ack || sl_dbus !== (exp_ack ? 32'h0004_0000 : 32'h0)) begin
        errors++; $display("FAIL b2b_cycle%0d ack=%b dbus=%h want %b", k, ack, sl_dbus, exp_ack);
      end
    end
    @(negedge clk); sel = 1'b0;
  endtask

  task automatic test_live;
    logic [31:0] rd; logic a; int lat;
    udi[64 +: 32] = 32'hDEAD_BEEF;
    xfer(32'h0C, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (a !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL live_ch2_a got %h acked=%b want deadbeef", rd, a);
    end
    udi[64 +: 32] = 32'h1234_5678;
    xfer(32'h0C, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++; $display("FAIL live_ch2_b got %h want 12345678", rd);
    end
  endtask

  task automatic test_snapshot;
    logic [31:0] rd; logic a; int lat;
    for (int i = 0; i < 4; i++) udi[32*i +: 32] = 32'(i + 1);
    xfer(32'h0, 1'b0, 4'b1111, 32'h3, rd, a, lat);
    @(posedge clk); #1;
    checks++;
    if (snap !== 1'b1) begin errors++; $display("FAIL snap_done_pulse got %b want 1", snap); end
    @(posedge clk); #1;
    checks++;
    if (snap !== 1'b0) begin errors++; $display("FAIL snap_done_single got %b want 0", snap); end
    for (int i = 0; i < 4; i++) udi[32*i +: 32] = 32'h9999_9999;
    for (int i = 0; i < 4; i++) begin
      xfer(32'(4 * (i + 1)), 1'b1, 4'b1111, 32'h0, rd, a, lat);
      checks++;
      if (rd !== 32'(i + 1)) begin
        errors++; $display("FAIL snap_ch%0d got %h want %h", i, rd, i + 1);
      end
    end
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h0004_0101) begin errors++; $display("FAIL snap_ctrl got %h want 00040101", rd); end
  endtask

  task automatic test_byte_enables;
    logic [31:0] rd; logic a; int lat;
    for (int i = 0; i < 4; i++) udi[32*i +: 32] = 32'h5500_0000 + 32'(i);
    xfer(32'h0, 1'b0, 4'b1110, 32'h3, rd, a, lat);
    @(posedge clk); #1;
    checks++;
    if (snap !== 1'b0) begin errors++; $display("FAIL be1110_snap got %b want 0", snap); end
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h0004_0101) begin errors++; $display("FAIL be1110_ctrl got %h want 00040101", rd); end
    xfer(32'h0, 1'b0, 4'b0001, 32'h3, rd, a, lat);
    @(posedge clk); #1;
    checks++;
    if (snap !== 1'b1) begin errors++; $display("FAIL be0001_snap got %b want 1", snap); end
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h0004_0201) begin errors++; $display("FAIL be0001_ctrl got %h want 00040201", rd); end
    xfer(32'h08, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h5500_0001) begin errors++; $display("FAIL be0001_ch1 got %h want 55000001", rd); end
  endtask

  task automatic test_out_of_map;
    logic [31:0] rd; logic a; int lat;
    xfer(32'h40, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (a !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL unmapped_read acked=%b got %h want 1/0", a, rd);
    end
    xfer(32'h100, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL outside_window acked=%b want 0", a); end
    xfer(32'h08, 1'b0, 4'b1111, 32'hFFFF_FFFF, rd, a, lat);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL chan_write_ack acked=%b want 1", a); end
    udi[32 +: 32] = 32'hCAFE_0001;
    xfer(32'h08, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h5500_0001) begin errors++; $display("FAIL chan_write_shadow got %h want 55000001", rd); end
    xfer(32'h0, 1'b0, 4'b0001, 32'h0, rd, a, lat);
    xfer(32'h08, 1'b0, 4'b1111, 32'h0, rd, a, lat);
    xfer(32'h08, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL chan_write_live got %h want cafe0001", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic a; int lat;
    for (int i = 0; i < 254; i++) xfer(32'h0, 1'b0, 4'b0001, 32'h2, rd, a, lat);
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h0004_0000) begin errors++; $display("FAIL cnt_wrap got %h want 00040000", rd); end
    for (int i = 0; i < 2; i++) xfer(32'h0, 1'b0, 4'b0001, 32'h2, rd, a, lat);
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h0004_0200) begin errors++; $display("FAIL cnt_after_wrap got %h want 00040200", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic a; int lat; logic seen;
    seen = 1'b0;
    @(negedge clk);
    abus = 32'h0; rnw_s = 1'b1; be_s = 4'b1111; sel = 1'b1;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0 || sl_dbus !== 32'h0 || snap !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_mid_outputs saw nonzero ack/dbus/snap want all 0"); end
    @(negedge clk); sel = 1'b0; rst_n = 1'b1;
    xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (a !== 1'b1 || rd !== 32'h0004_0000) begin
      errors++; $display("FAIL rst_mid_ctrl acked=%b got %h want 00040000", a, rd);
    end
    xfer(32'h0, 1'b0, 4'b0001, 32'h1, rd, a, lat);
    xfer(32'h04, 1'b1, 4'b1111, 32'h0, rd, a, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_shadow_clear got %h want 0", rd); end
  endtask

  initial begin
    rst_n = 1'b0; abus = '0; dbus = '0; be_s = '0; rnw_s = 1'b1;
    sel = 1'b0; seqaddr = 1'b0; udi = '0;
    test_reset();
    test_back_to_back();
    test_live();
    test_snapshot();
    test_byte_enables();
    test_out_of_map();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_simulink2ppc.md
Name: opb_register_bank_simulink2ppc

Overview:
- Single-clock OPB slave exposing N_REGS user-logic 32-bit values to the PPC as a bank of read-only registers, plus one control/status word.
- Successor to the single-register simulink2ppc block: parametrised channel count, and an atomic snapshot mode so multi-word values (counters, status sets) are read coherently.
- User logic runs on OPB_Clk. There is no clock-domain crossing in this block.

Parameters:
- C_BASEADDR, 32'h00000000, first byte address of the slave window.
- C_HIGHADDR, 32'h000000FF, last byte address of the slave window. Size is at least 4*(N_REGS+1) bytes.
- C_OPB_AWIDTH, 32, address bus width.
- C_OPB_DWIDTH, 32, data bus width. Only 32 is supported.
- N_REGS, 4, number of user channels, 1..63.
- C_FAMILY, "virtex6", target family string. Passed through only.

Ports:
- OPB_Clk  in  1  bus and user clock.
- OPB_Rst  in  1  synchronous reset, active-low (0 = reset), sampled on the OPB_Clk rising edge.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables. BE[0] selects DBus[0:7], which maps to register bits 31:24.
- OPB_DBus  in  [0:31]  write data. DBus[0] is the MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_in  in  32*N_REGS  channel i occupies bits [32*i+31:32*i].
- snap_done  out  1  one-cycle pulse when a snapshot is captured.

Behaviour:
- Address decode:
  - hit = OPB_select AND C_BASEADDR <= ABus <= C_HIGHADDR.
  - word index w = (ABus - C_BASEADDR) >> 2.
  - w = 0 is the CTRL register. w = 1..N_REGS is channel w-1. Any other w inside the window reads 0, ignores writes, and is still acked.
- Handshake:
  - Sl_xferAck <= hit AND NOT Sl_xferAck, registered.
  - The ack goes high exactly one cycle after select, lasts one cycle, and never occurs on two consecutive cycles. Minimum transfer is therefore 2 cycles.
  - Sl_DBus is registered together with the ack. It carries valid data only while Sl_xferAck = 1 and is all-zero otherwise, so wired-OR bus sharing works.
- Read/write commit:
  - Writes commit on the cycle the ack is asserted, using that cycle's DBus/BE.
  - The read value is the one sampled on the cycle the ack is registered.
- CTRL (w = 0):
  - bit0 SNAP_MODE, RW, reset 0.
  - bit1 SNAP_TRIG, write-1 pulse, always reads 0.
  - bits15:8 SNAP_CNT, RO, reset 0, wraps 255 -> 0.
  - bits23:16 N_REGS constant, RO.
  - All other bits read 0.
  - A write takes effect only for byte lanes whose BE bit is set. BE[3] covers bits 7:0.
- Snapshot:
  - A SNAP_TRIG write captures all N_REGS values of user_data_in into a shadow bank.
  - The values captured are those presented on the cycle the write commits, all taken in the same cycle.
  - In that same cycle: SNAP_CNT increments, and snap_done pulses for 1 cycle, high the cycle after the commit.
  - If SNAP_TRIG and SNAP_MODE are written together, the mode update and the capture both occur in that cycle.
- Channel reads:
  - SNAP_MODE = 0: the read returns live user_data_in for the channel, as sampled on the ack-register cycle.
  - SNAP_MODE = 1: the read returns the shadow value.
  - Writes to channel words are acked and discarded.
- Reset (OPB_Rst = 0 at a clock edge):
  - Sl_xferAck = 0, Sl_DBus = 0, snap_done = 0, SNAP_MODE = 0, SNAP_CNT = 0, shadow bank = 0.
  - A transfer in progress is dropped with no ack. The master times out or reissues.
  - Reset takes priority over every simultaneous event.
- Select deasserted before the ack: the pending ack is still issued the next cycle, since it was registered from the hit. Masters must not drop select early.

Test Plan:
- Reset then read CTRL with N_REGS = 4 -> ack one cycle after select, Sl_DBus = 0x00040000, Sl_DBus = 0 on all non-ack cycles.
- Live mode: ch2 input = 0xDEADBEEF, read base+0x0C -> 0xDEADBEEF. Change the input to 0x12345678, read again -> 0x12345678.
- Snapshot coherency:
  - Inputs ch0..3 = 1, 2, 3, 4. Write CTRL = 0x3 -> snap_done pulses once, SNAP_CNT = 1.
  - Change the inputs to 9s. Reads of ch0..3 -> 1, 2, 3, 4. Read CTRL -> 0x00040101.
- Byte enables: write CTRL data 0x00000003 with BE = 1110 -> no change, SNAP_CNT stays and snap_done stays 0. With BE = 0001 -> the snapshot fires.
- Out-of-map and wrap:
  - Read base+0x40 -> ack with data 0.
  - 256 triggers -> SNAP_CNT wraps to 0.
  - Write to a channel word -> ack, and the value is unchanged on readback.
- Reset mid-transfer: assert OPB_Rst = 0 on the cycle after select rises -> no ack, all outputs 0. After release, a normal read succeeds and CTRL = 0x00040000.
